// File: rtl/nnrv_if_pf_if.sv
// Fetch unit bus bundle: memory read channel plus decode-side instruction
// channel. Signal names match the original flat port list.
interface nnrv_if_pf_if #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic                   o_mem_req;
  logic [XLEN-1:0]        o_mem_addr;
  logic                   i_mem_gnt;
  logic                   i_mem_rvalid;
  logic [DATA_WIDTH-1:0]  i_mem_rdata;
  logic                   o_id_valid;
  logic [INSTR_WIDTH-1:0] o_id_instr;
  logic [XLEN-1:0]        o_id_cur_pc;
  logic                   i_id_ready;
  logic                   i_id_jmp_valid;
  logic [XLEN-1:0]        i_id_jmp_pc;

  // Fetch unit side
  modport master (
    output o_mem_req, o_mem_addr, o_id_valid, o_id_instr, o_id_cur_pc,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_id_ready,
    input  i_id_jmp_valid, i_id_jmp_pc
  );

  // Memory / decode side
  modport slave (
    input  o_mem_req, o_mem_addr, o_id_valid, o_id_instr, o_id_cur_pc,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_id_ready,
    output i_id_jmp_valid, i_id_jmp_pc
  );
endinterface

// File: rtl/nnrv_if_pf.sv
// Instruction prefetcher: issues 8-byte aligned reads, splits each 64-bit
// beat into one or two 32-bit instructions and queues them for decode.
// Redirects flush the queue and discard any in-flight response.
module nnrv_if_pf #(
  parameter int unsigned    XLEN        = 64,
  parameter int unsigned    DATA_WIDTH  = 64,
  parameter int unsigned    INSTR_WIDTH = 32,
  parameter int unsigned    FIFO_DEPTH  = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input logic           i_clk,
  input logic           i_rst,
  nnrv_if_pf_if.master  bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DISCARD
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic            hold_q, hold_d;          // request raised, not yet granted
  logic [XLEN-1:0] hold_addr_q, hold_addr_d;
  logic            disc_q, disc_d;          // held request must be discarded
  logic [XLEN-1:0] iss_addr_q, iss_addr_d;  // address of outstanding read
  logic            iss_hi_q, iss_hi_d;      // outstanding read started at upper word

  logic [INSTR_WIDTH-1:0] instr_mem [FIFO_DEPTH];
  logic [XLEN-1:0]        pc_mem    [FIFO_DEPTH];
  logic [AW-1:0]          wptr_q, wptr_d;
  logic [AW-1:0]          rptr_q, rptr_d;
  logic [LW-1:0]          level_q, level_d;

  logic                   jmp;
  logic                   req;
  logic                   gnt;
  logic                   pop;
  logic [XLEN-1:0]        fetch_addr;
  logic [XLEN-1:0]        req_addr;
  logic [LW-1:0]          free_slots;
  logic [LW-1:0]          need_slots;
  logic                   push0, push1;
  logic [LW-1:0]          push_cnt;
  logic [INSTR_WIDTH-1:0] push0_instr, push1_instr;
  logic [XLEN-1:0]        push0_pc, push1_pc;
  logic [INSTR_WIDTH-1:0] rd_lo, rd_hi;

  // Request generation and datapath helpers
  always_comb begin
    jmp        = bus.i_id_jmp_valid;
    fetch_addr = fpc_q & ~XLEN'(7);
    free_slots = LW'(FIFO_DEPTH) - level_q;
    need_slots = fpc_q[2] ? LW'(1) : LW'(2);
    // A held request stays up regardless of FIFO room so the handshake completes.
    req        = !i_rst && (state_q == ST_IDLE) && (hold_q || (free_slots >= need_slots));
    req_addr   = hold_q ? hold_addr_q : fetch_addr;
    gnt        = req && bus.i_mem_gnt;
    pop        = (level_q != '0) && bus.i_id_ready && !jmp;
    rd_lo      = bus.i_mem_rdata[INSTR_WIDTH-1:0];
    rd_hi      = bus.i_mem_rdata[2*INSTR_WIDTH-1:INSTR_WIDTH];
  end

  // Next-state logic: fetch FSM, fetch pointer, push control
  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    hold_d      = hold_q;
    hold_addr_d = hold_addr_q;
    disc_d      = disc_q;
    iss_addr_d  = iss_addr_q;
    iss_hi_d    = iss_hi_q;
    push0       = 1'b0;
    push1       = 1'b0;
    push0_instr = iss_hi_q ? rd_hi : rd_lo;
    push0_pc    = iss_hi_q ? (iss_addr_q + XLEN'(4)) : iss_addr_q;
    push1_instr = rd_hi;
    push1_pc    = iss_addr_q + XLEN'(4);

    unique case (state_q)
      ST_IDLE: begin
        if (gnt) begin
          hold_d = 1'b0;
          disc_d = 1'b0;
          if (jmp || disc_q) begin
            state_d = ST_DISCARD;
          end else begin
            state_d    = ST_WAIT;
            iss_addr_d = req_addr;
            iss_hi_d   = fpc_q[2];
            fpc_d      = fetch_addr + XLEN'(8);
          end
        end else if (req) begin
          hold_d      = 1'b1;
          hold_addr_d = req_addr;
          if (jmp) disc_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.i_mem_rvalid) begin
          state_d = ST_IDLE;
          if (!jmp) begin
            push0 = 1'b1;
            push1 = !iss_hi_q;
          end
        end else if (jmp) begin
          state_d = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (bus.i_mem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (jmp) fpc_d = bus.i_id_jmp_pc;
  end

  // FIFO pointer and level bookkeeping
  always_comb begin
    push_cnt = LW'(push0) + LW'(push1);
    wptr_d   = wptr_q + AW'(push_cnt);
    rptr_d   = rptr_q + AW'(pop);
    level_d  = level_q + push_cnt - LW'(pop);
    if (jmp) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end
  end

  // Control state registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      fpc_q       <= RESET_PC;
      hold_q      <= 1'b0;
      hold_addr_q <= '0;
      disc_q      <= 1'b0;
      iss_addr_q  <= '0;
      iss_hi_q    <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      hold_q      <= hold_d;
      hold_addr_q <= hold_addr_d;
      disc_q      <= disc_d;
      iss_addr_q  <= iss_addr_d;
      iss_hi_q    <= iss_hi_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
    end
  end

  // FIFO storage writes; contents are qualified by level so need no reset
  always_ff @(posedge i_clk) begin
    if (!i_rst && push0) begin
      instr_mem[wptr_q] <= push0_instr;
      pc_mem[wptr_q]    <= push0_pc;
    end
    if (!i_rst && push1) begin
      instr_mem[AW'(wptr_q + 1'b1)] <= push1_instr;
      pc_mem[AW'(wptr_q + 1'b1)]    <= push1_pc;
    end
  end

  // Output drive
  always_comb begin
    bus.o_mem_req   = req;
    bus.o_mem_addr  = req_addr;
    bus.o_id_valid  = (level_q != '0);
    bus.o_id_instr  = (level_q != '0) ? instr_mem[rptr_q] : NOP;
    bus.o_id_cur_pc = (level_q != '0) ? pc_mem[rptr_q] : '0;
  end

endmodule

// File: tb/tb_nnrv_if_pf.sv
// Directed bench for the instruction prefetcher.
module tb_nnrv_if_pf;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  nnrv_if_pf_if #(.XLEN(64), .DATA_WIDTH(64), .INSTR_WIDTH(32)) bus ();

  nnrv_if_pf #(
    .XLEN(64), .DATA_WIDTH(64), .INSTR_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(64'h0)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    tick; tick;
    checks++;
    if (bus.o_mem_req !== 1'b0 || bus.o_id_valid !== 1'b0 ||
        bus.o_id_instr !== NOP || bus.o_id_cur_pc !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b valid=%b instr=%h pc=%h expected 0 0 %h 0",
               bus.o_mem_req, bus.o_id_valid, bus.o_id_instr, bus.o_id_cur_pc, NOP);
    end
    i_rst = 1'b0;
    #1;
    checks++;
    if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 64'h0) begin
      errors++;
      $display("FAIL reset_first_req: req=%b addr=%h expected 1 0", bus.o_mem_req, bus.o_mem_addr);
    end
  endtask

  task automatic test_basic;
    bus.i_id_ready = 1'b1;
    bus.i_mem_gnt = 1'b1;
    tick;
    bus.i_mem_gnt = 1'b0;
    checks++;
    if (bus.o_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL basic_wait_noreq: req=%b expected 0", bus.o_mem_req);
    end
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata = 64'h00200093_00100093;
    tick;
    bus.i_mem_rvalid = 1'b0;
    checks++;
    if (bus.o_id_valid !== 1'b1 || bus.o_id_instr !== 32'h00100093 || bus.o_id_cur_pc !== 64'h0) begin
      errors++;
      $display("FAIL basic_first: valid=%b instr=%h pc=%h expected 1 00100093 0",
               bus.o_id_valid, bus.o_id_instr, bus.o_id_cur_pc);
    end
    checks++;
    if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 64'h8) begin
      errors++;
      $display("FAIL basic_next_req: req=%b addr=%h expected 1 8", bus.o_mem_req, bus.o_mem_addr);
    end
    tick;
    checks++;
    if (bus.o_id_valid !== 1'b1 || bus.o_id_instr !== 32'h00200093 || bus.o_id_cur_pc !== 64'h4) begin
      errors++;
      $display("FAIL basic_second: valid=%b instr=%h pc=%h expected 1 00200093 4",
               bus.o_id_valid, bus.o_id_instr, bus.o_id_cur_pc);
    end
    tick;
    bus.i_id_ready = 1'b0;
    checks++;
    if (bus.o_id_valid !== 1'b0 || bus.o_id_instr !== NOP || bus.o_id_cur_pc !== 64'h0) begin
      errors++;
      $display("FAIL basic_empty: valid=%b instr=%h pc=%h expected 0 %h 0",
               bus.o_id_valid, bus.o_id_instr, bus.o_id_cur_pc, NOP);
    end
  endtask

  task automatic test_fill;
    bus.i_mem_gnt = 1'b1; tick; bus.i_mem_gnt = 1'b0;
    bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 64'h11111111_22222222; tick; bus.i_mem_rvalid = 1'b0;
    checks++;
    if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 64'h10 || bus.o_id_cur_pc !== 64'h8) begin
      errors++;
      $display("FAIL fill_second_req: req=%b addr=%h head_pc=%h expected 1 10 8",
               bus.o_mem_req, bus.o_mem_addr, bus.o_id_cur_pc);
    end
    bus.i_mem_gnt = 1'b1; tick; bus.i_mem_gnt = 1'b0;
    bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 64'h33333333_44444444; tick; bus.i_mem_rvalid = 1'b0;
    checks++;
    if (bus.o_mem_req !== 1'b0 || bus.o_id_instr !== 32'h22222222 || bus.o_id_cur_pc !== 64'h8) begin
      errors++;
      $display("FAIL fill_full: req=%b instr=%h pc=%h expected 0 22222222 8",
               bus.o_mem_req, bus.o_id_instr, bus.o_id_cur_pc);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (bus.o_mem_req !== 1'b0) begin
        errors++;
        $display("FAIL fill_hold_noreq: cycle %0d req=%b expected 0", i, bus.o_mem_req);
      end
    end
    bus.i_id_ready = 1'b1; tick; bus.i_id_ready = 1'b0;
    checks++;
    if (bus.o_mem_req !== 1'b0 || bus.o_id_instr !== 32'h11111111 || bus.o_id_cur_pc !== 64'hC) begin
      errors++;
      $display("FAIL fill_level3: req=%b instr=%h pc=%h expected 0 11111111 c",
               bus.o_mem_req, bus.o_id_instr, bus.o_id_cur_pc);
    end
    bus.i_id_ready = 1'b1; tick; bus.i_id_ready = 1'b0;
    checks++;
    if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 64'h18 ||
        bus.o_id_instr !== 32'h44444444 || bus.o_id_cur_pc !== 64'h10) begin
      errors++;
      $display("FAIL fill_level2: req=%b addr=%h instr=%h pc=%h expected 1 18 44444444 10",
               bus.o_mem_req, bus.o_mem_addr, bus.o_id_instr, bus.o_id_cur_pc);
    end
  endtask

  task automatic test_jump_wait;
    bus.i_mem_gnt = 1'b1; tick; bus.i_mem_gnt = 1'b0;
    bus.i_id_jmp_valid = 1'b1; bus.i_id_jmp_pc = 64'h104; tick; bus.i_id_jmp_valid = 1'b0;
    checks++;
    if (bus.o_id_valid !== 1'b0 || bus.o_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL jw_discard: valid=%b req=%b expected 0 0", bus.o_id_valid, bus.o_mem_req);
    end
    bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 64'hDEADBEEF_CAFEF00D; tick; bus.i_mem_rvalid = 1'b0;
    checks++;
    if (bus.o_id_valid !== 1'b0 || bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 64'h100) begin
      errors++;
      $display("FAIL jw_stale_drop: valid=%b req=%b addr=%h expected 0 1 100",
               bus.o_id_valid, bus.o_mem_req, bus.o_mem_addr);
    end
    bus.i_mem_gnt = 1'b1; tick; bus.i_mem_gnt = 1'b0;
    bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 64'h00500293_00400213; tick; bus.i_mem_rvalid = 1'b0;
    checks++;
    if (bus.o_id_valid !== 1'b1 || bus.o_id_instr !== 32'h00500293 || bus.o_id_cur_pc !== 64'h104) begin
      errors++;
      $display("FAIL jw_upper_only: valid=%b instr=%h pc=%h expected 1 00500293 104",
               bus.o_id_valid, bus.o_id_instr, bus.o_id_cur_pc);
    end
    checks++;
    if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 64'h108) begin
      errors++;
      $display("FAIL jw_next_req: req=%b addr=%h expected 1 108", bus.o_mem_req, bus.o_mem_addr);
    end
    bus.i_id_ready = 1'b1; tick; bus.i_id_ready = 1'b0;
    checks++;
    if (bus.o_id_valid !== 1'b0) begin
      errors++;
      $display("FAIL jw_single_push: valid=%b expected 0", bus.o_id_valid);
    end
  endtask

  task automatic test_jump_rvalid_pop;
    bus.i_mem_gnt = 1'b1; tick; bus.i_mem_gnt = 1'b0;
    bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 64'h00700393_00600313; tick; bus.i_mem_rvalid = 1'b0;
    checks++;
    if (bus.o_id_cur_pc !== 64'h108 || bus.o_mem_addr !== 64'h110) begin
      errors++;
      $display("FAIL jrp_setup: pc=%h addr=%h expected 108 110", bus.o_id_cur_pc, bus.o_mem_addr);
    end
    bus.i_mem_gnt = 1'b1; tick; bus.i_mem_gnt = 1'b0;
    bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 64'h0000006F_0000006F;
    bus.i_id_jmp_valid = 1'b1; bus.i_id_jmp_pc = 64'h200; bus.i_id_ready = 1'b1;
    tick;
    bus.i_mem_rvalid = 1'b0; bus.i_id_jmp_valid = 1'b0; bus.i_id_ready = 1'b0;
    checks++;
    if (bus.o_id_valid !== 1'b0 || bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 64'h200) begin
      errors++;
      $display("FAIL jrp_flush: valid=%b req=%b addr=%h expected 0 1 200",
               bus.o_id_valid, bus.o_mem_req, bus.o_mem_addr);
    end
    bus.i_mem_gnt = 1'b1; tick; bus.i_mem_gnt = 1'b0;
    bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 64'h00900493_00800413; tick; bus.i_mem_rvalid = 1'b0;
    checks++;
    if (bus.o_id_instr !== 32'h00800413 || bus.o_id_cur_pc !== 64'h200) begin
      errors++;
      $display("FAIL jrp_target_head: instr=%h pc=%h expected 00800413 200",
               bus.o_id_instr, bus.o_id_cur_pc);
    end
    bus.i_id_ready = 1'b1; tick;
    checks++;
    if (bus.o_id_instr !== 32'h00900493 || bus.o_id_cur_pc !== 64'h204) begin
      errors++;
      $display("FAIL jrp_target_second: instr=%h pc=%h expected 00900493 204",
               bus.o_id_instr, bus.o_id_cur_pc);
    end
    tick; bus.i_id_ready = 1'b0;
  endtask

  task automatic test_gnt_delay;
    tick;
    checks++;
    if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 64'h208) begin
      errors++;
      $display("FAIL gd_stable1: req=%b addr=%h expected 1 208", bus.o_mem_req, bus.o_mem_addr);
    end
    bus.i_id_jmp_valid = 1'b1; bus.i_id_jmp_pc = 64'h300; tick; bus.i_id_jmp_valid = 1'b0;
    checks++;
    if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 64'h208) begin
      errors++;
      $display("FAIL gd_stable_after_jump: req=%b addr=%h expected 1 208", bus.o_mem_req, bus.o_mem_addr);
    end
    tick;
    checks++;
    if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 64'h208) begin
      errors++;
      $display("FAIL gd_stable3: req=%b addr=%h expected 1 208", bus.o_mem_req, bus.o_mem_addr);
    end
    bus.i_mem_gnt = 1'b1; tick; bus.i_mem_gnt = 1'b0;
    checks++;
    if (bus.o_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL gd_discard: req=%b expected 0", bus.o_mem_req);
    end
    bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 64'h12345678_9ABCDEF0; tick; bus.i_mem_rvalid = 1'b0;
    checks++;
    if (bus.o_id_valid !== 1'b0 || bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 64'h300) begin
      errors++;
      $display("FAIL gd_dropped: valid=%b req=%b addr=%h expected 0 1 300",
               bus.o_id_valid, bus.o_mem_req, bus.o_mem_addr);
    end
  endtask

  task automatic test_jump_gnt;
    bus.i_mem_gnt = 1'b1; bus.i_id_jmp_valid = 1'b1; bus.i_id_jmp_pc = 64'h404;
    tick;
    bus.i_mem_gnt = 1'b0; bus.i_id_jmp_valid = 1'b0;
    checks++;
    if (bus.o_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL jg_discard: req=%b expected 0", bus.o_mem_req);
    end
    bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 64'hFFFFFFFF_EEEEEEEE; tick; bus.i_mem_rvalid = 1'b0;
    checks++;
    if (bus.o_id_valid !== 1'b0 || bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 64'h400) begin
      errors++;
      $display("FAIL jg_target_req: valid=%b req=%b addr=%h expected 0 1 400",
               bus.o_id_valid, bus.o_mem_req, bus.o_mem_addr);
    end
    bus.i_mem_gnt = 1'b1; tick; bus.i_mem_gnt = 1'b0;
    bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 64'h00B00593_00A00513; tick; bus.i_mem_rvalid = 1'b0;
    checks++;
    if (bus.o_id_instr !== 32'h00B00593 || bus.o_id_cur_pc !== 64'h404) begin
      errors++;
      $display("FAIL jg_head: instr=%h pc=%h expected 00b00593 404", bus.o_id_instr, bus.o_id_cur_pc);
    end
    bus.i_id_ready = 1'b1; tick; bus.i_id_ready = 1'b0;
  endtask

  task automatic test_reset_in_wait;
    bus.i_mem_gnt = 1'b1; tick; bus.i_mem_gnt = 1'b0;
    i_rst = 1'b1; tick;
    checks++;
    if (bus.o_mem_req !== 1'b0 || bus.o_id_valid !== 1'b0 ||
        bus.o_id_instr !== NOP || bus.o_id_cur_pc !== 64'h0) begin
      errors++;
      $display("FAIL rw_reset_outputs: req=%b valid=%b instr=%h pc=%h expected 0 0 %h 0",
               bus.o_mem_req, bus.o_id_valid, bus.o_id_instr, bus.o_id_cur_pc, NOP);
    end
    i_rst = 1'b0;
    bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 64'hBAD0BAD0_BAD0BAD0;
    tick;
    bus.i_mem_rvalid = 1'b0;
    checks++;
    if (bus.o_id_valid !== 1'b0 || bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 64'h0) begin
      errors++;
      $display("FAIL rw_late_rvalid: valid=%b req=%b addr=%h expected 0 1 0",
               bus.o_id_valid, bus.o_mem_req, bus.o_mem_addr);
    end
    bus.i_mem_gnt = 1'b1; tick; bus.i_mem_gnt = 1'b0;
    bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 64'h00D00693_00C00613; tick; bus.i_mem_rvalid = 1'b0;
    checks++;
    if (bus.o_id_valid !== 1'b1 || bus.o_id_instr !== 32'h00C00613 || bus.o_id_cur_pc !== 64'h0) begin
      errors++;
      $display("FAIL rw_restart: valid=%b instr=%h pc=%h expected 1 00c00613 0",
               bus.o_id_valid, bus.o_id_instr, bus.o_id_cur_pc);
    end
  endtask

  initial begin
    bus.i_mem_gnt      = 1'b0;
    bus.i_mem_rvalid   = 1'b0;
    bus.i_mem_rdata    = '0;
    bus.i_id_ready     = 1'b0;
    bus.i_id_jmp_valid = 1'b0;
    bus.i_id_jmp_pc    = '0;
    test_reset;
    test_basic;
    test_fill;
    test_jump_wait;
    test_jump_rvalid_pop;
    test_gnt_delay;
    test_jump_gnt;
    test_reset_in_wait;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nnrv_if_pf.md
NNRV_IF_PF -- requirements
Module: nnrv_if_pf

Interface
Parameters:
REQ-001 The block SHALL have parameter XLEN, default 64, address and PC width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 64, memory read data width; fixed at 64 for this generation.
REQ-003 The block SHALL have parameter INSTR_WIDTH, default 32, instruction width.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, prefetch entries; power of two, >= 2.
REQ-005 The block SHALL have parameter RESET_PC, default 0, fetch start address; 4-byte aligned.

Ports:
REQ-006 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port o_mem_req, output, 1 bit: read request valid.
REQ-009 The block SHALL have port o_mem_addr, output, XLEN bits: request address, 8-byte aligned (bits [2:0]=0).
REQ-010 The block SHALL have port i_mem_gnt, input, 1 bit: request accepted this cycle.
REQ-011 The block SHALL have port i_mem_rvalid, input, 1 bit: read data valid.
REQ-012 The block SHALL have port i_mem_rdata, input, DATA_WIDTH bits: read data.
REQ-013 The block SHALL have port o_id_valid, output, 1 bit: the instruction at the FIFO head is valid.
REQ-014 The block SHALL have port o_id_instr, output, INSTR_WIDTH bits: head instruction; 32'h00000013 (NOP) when o_id_valid=0.
REQ-015 The block SHALL have port o_id_cur_pc, output, XLEN bits: PC of the head instruction; 0 when o_id_valid=0.
REQ-016 The block SHALL have port i_id_ready, input, 1 bit: decode consumes the head when o_id_valid=1.
REQ-017 The block SHALL have port i_id_jmp_valid, input, 1 bit: redirect request.
REQ-018 The block SHALL have port i_id_jmp_pc, input, XLEN bits: redirect target, 4-byte aligned.

Function
REQ-019 The block SHALL keep a fetch pointer fpc, the PC of the next instruction to request; on request grant, fpc SHALL become (fpc & ~7) + 8.
REQ-020 The block SHALL implement an FSM with states IDLE, WAIT and DISCARD.
REQ-021 IDLE: o_mem_req SHALL be 1 iff free FIFO slots >= n, where n=2 if fpc[2]=0 and n=1 if fpc[2]=1; o_mem_addr SHALL be fpc & ~7.
REQ-022 While o_mem_req=1 and i_mem_gnt=0, o_mem_req and o_mem_addr SHALL hold stable.
REQ-023 On gnt, the FSM SHALL move to WAIT; at most one outstanding request at any time; o_mem_req=0 outside IDLE.
REQ-024 WAIT with rvalid=1: if fpc[2] at the time of issue was 0, the block SHALL push rdata[31:0] (pc=A) then rdata[63:32] (pc=A+4); if it was 1, only rdata[63:32] (pc=A+4); the FSM SHALL then return to IDLE.
REQ-025 Latency: the earliest o_id_valid SHALL appear the cycle after the rvalid that delivers the data (registered FIFO, no bypass).
REQ-026 Pop: the head SHALL be popped when o_id_valid & i_id_ready; push and pop in the same cycle SHALL both take effect, and the level SHALL update as level + pushed - popped.
REQ-027 The FIFO SHALL use wrap-around read/write pointers of log2(FIFO_DEPTH) bits plus a level counter of log2(FIFO_DEPTH)+1 bits; it SHALL never overflow, guaranteed by the REQ-021 issue rule.
REQ-028 Jump (i_id_jmp_valid=1): the block SHALL flush the FIFO (level=0), set fpc=i_id_jmp_pc, and suppress any pop in that cycle; o_id_valid SHALL be 0 the following cycle.
REQ-029 On a jump in WAIT without rvalid, or in IDLE with a pending un-granted request, the outstanding or pending response SHALL be discarded: the pending request completes its handshake, then the FSM goes to DISCARD.
REQ-030 On a jump coinciding with rvalid, that data SHALL be dropped and the FSM SHALL go to IDLE.
REQ-031 DISCARD: no request; on rvalid the data SHALL be dropped and the FSM SHALL go to IDLE; a further jump in DISCARD SHALL only update fpc.
REQ-032 On a jump coinciding with gnt in IDLE, the FSM SHALL go to DISCARD and fpc SHALL take the jump target.

Reset
REQ-033 When i_rst=1 at a clock edge: fpc=RESET_PC, FSM=IDLE, FIFO level/pointers=0, o_id_valid=0, o_id_instr=NOP, o_id_cur_pc=0, o_mem_req=0 in that cycle.
REQ-034 Reset SHALL override jump, grant and rvalid in the same cycle; a response arriving after reset for a request issued before reset SHALL be ignored (the FSM is in IDLE and the block SHALL treat rvalid in IDLE as stale).

Verification
REQ-035 The bench SHALL cover: reset, then memory with gnt same cycle and rvalid 1 cycle later with rdata=64'h00200093_00100093, i_id_ready=1 -> o_id_instr 00100093@pc0, then 00200093@pc4, then next request addr 8.
REQ-036 The bench SHALL cover: i_id_ready=0 with FIFO_DEPTH=4 -> exactly 2 grants, level 4, o_mem_req=0 held; ready=1 for one cycle -> level 3, still no request until level <= 2.
REQ-037 The bench SHALL cover: jump to 0x104 while in WAIT -> stale rvalid dropped, next o_mem_addr=0x100, only rdata[63:32] pushed, head pc=0x104.
REQ-038 The bench SHALL cover: jump coinciding with rvalid and with a pop -> no push, no pop, o_id_valid=0 next cycle, FSM IDLE, request to new target.
REQ-039 The bench SHALL cover: gnt delayed 3 cycles -> o_mem_req/o_mem_addr stable throughout; jump during the delay -> DISCARD after gnt, response dropped.
REQ-040 The bench SHALL cover: i_rst asserted in WAIT -> next cycle all outputs at reset values; late rvalid ignored; fetch restarts at RESET_PC.
